// File: rtl/rv_load_store_unit_if.sv
// Request/response handshake plus word-addressed memory port of the load/store unit.
// The slave side is the unit itself; the master side is the core plus the memory it talks to.
interface rv_load_store_unit_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_is_store;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_error;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rstrb;
  logic [31:0]       mem_rdata;
  logic [31:0]       mem_wdata;
  logic [3:0]        mem_wmask;

  modport master (
    output req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_error,
           mem_addr, mem_rstrb, mem_wdata, mem_wmask
  );

  modport slave (
    input  req_valid, req_is_store, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_error,
           mem_addr, mem_rstrb, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/rv_load_store_unit.sv
// RISC-V LOAD/STORE memory stage: latches one request, issues a byte-masked word access to a
// synchronous RAM and returns the extended load result (or an alignment/funct3 error).
module rv_load_store_unit #(
  parameter int ADDR_W = 8
) (
  input  logic                clk,
  input  logic                reset,
  rv_load_store_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state;
  state_t            nextState;
  logic              accept;
  logic              reqErr;
  logic [31:0]       storeData;
  logic [3:0]        storeMask;
  logic [31:0]       loadData;
  logic [7:0]        loadByte;
  logic [15:0]       loadHalf;

  logic              isStore;
  logic [2:0]        funct3;
  logic [ADDR_W+1:0] addrLat;
  logic [31:0]       wdataLat;
  logic [3:0]        wmaskLat;
  logic [31:0]       rdataReg;
  logic              errorReg;

  // Address bits above the memory size wrap silently.
  logic unusedAddrBits;
  assign unusedAddrBits = ^bus.req_addr[31:ADDR_W+2];

  assign accept = bus.req_valid && (state == IDLE) && !reset;

  always_comb begin
    reqErr = 1'b0;
    case (bus.req_funct3)
      3'b000, 3'b100: reqErr = 1'b0;
      3'b001, 3'b101: reqErr = bus.req_addr[0];
      3'b010:         reqErr = |bus.req_addr[1:0];
      default:        reqErr = 1'b1;
    endcase
    if (bus.req_is_store && bus.req_funct3[2]) begin
      reqErr = 1'b1;
    end
  end

  always_comb begin
    storeData = bus.req_wdata;
    storeMask = 4'b1111;
    case (bus.req_funct3[1:0])
      2'b00: begin
        storeData = {4{bus.req_wdata[7:0]}};
        storeMask = 4'b0001 << bus.req_addr[1:0];
      end
      2'b01: begin
        storeData = {2{bus.req_wdata[15:0]}};
        storeMask = 4'b0011 << bus.req_addr[1:0];
      end
      default: begin
        storeData = bus.req_wdata;
        storeMask = 4'b1111;
      end
    endcase
  end

  // Lane selection for loads uses the latched low address bits.
  always_comb begin
    loadByte = bus.mem_rdata[7:0];
    case (addrLat[1:0])
      2'b00:   loadByte = bus.mem_rdata[7:0];
      2'b01:   loadByte = bus.mem_rdata[15:8];
      2'b10:   loadByte = bus.mem_rdata[23:16];
      default: loadByte = bus.mem_rdata[31:24];
    endcase
    loadHalf = addrLat[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];
    case (funct3)
      3'b000:  loadData = {{24{loadByte[7]}}, loadByte};
      3'b100:  loadData = {24'b0, loadByte};
      3'b001:  loadData = {{16{loadHalf[15]}}, loadHalf};
      3'b101:  loadData = {16'b0, loadHalf};
      default: loadData = bus.mem_rdata;
    endcase
  end

  always_comb begin
    nextState = state;
    case (state)
      IDLE:    if (accept) nextState = reqErr ? RESP : ISSUE;
      ISSUE:   nextState = isStore ? RESP : WAIT;
      WAIT:    nextState = RESP;
      RESP:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Store lanes and mask are formed at accept so the memory port stays stable afterwards.
  always_ff @(posedge clk) begin
    if (reset) begin
      isStore  <= 1'b0;
      funct3   <= 3'b000;
      addrLat  <= '0;
      wdataLat <= 32'b0;
      wmaskLat <= 4'b0;
      rdataReg <= 32'b0;
      errorReg <= 1'b0;
    end else begin
      if (accept) begin
        isStore  <= bus.req_is_store;
        funct3   <= bus.req_funct3;
        addrLat  <= bus.req_addr[ADDR_W+1:0];
        wdataLat <= storeData;
        wmaskLat <= storeMask;
        rdataReg <= 32'b0;
        errorReg <= reqErr;
      end
      if (state == WAIT) begin
        rdataReg <= loadData;
      end
    end
  end

  assign bus.req_ready  = (state == IDLE) && !reset;
  assign bus.resp_valid = (state == RESP) && !reset;
  assign bus.resp_error = errorReg && bus.resp_valid;
  assign bus.resp_rdata = rdataReg;
  assign bus.mem_addr   = addrLat[ADDR_W+1:2];
  assign bus.mem_wdata  = wdataLat;
  // Strobes are gated by reset so a reset landing in ISSUE kills the access that same cycle.
  assign bus.mem_rstrb  = (state == ISSUE) && !isStore && !reset;
  assign bus.mem_wmask  = ((state == ISSUE) && isStore && !reset) ? wmaskLat : 4'b0000;

endmodule

// File: tb/tb_rv_load_store_unit.sv
// Directed self-checking bench for rv_load_store_unit with a synchronous RAM model.
module tb_rv_load_store_unit;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   failures = 0;

  int          rstrbCycles = 0;
  int          wmaskCycles = 0;
  int          respCycles = 0;
  logic [7:0]  lastRaddr = 8'h0;
  logic [7:0]  lastWaddr = 8'h0;
  logic [3:0]  lastMask = 4'h0;
  logic [31:0] lastWdata = 32'h0;
  logic [31:0] mem [256];

  rv_load_store_unit_if #(.ADDR_W(8)) bus ();

  rv_load_store_unit #(.ADDR_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // RAM model: preloaded while reset is high, read data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[0] = 32'h80FF7F01;
      mem[1] = 32'h11223344;
      mem[5] = 32'hDEADBEEF;
      mem[8] = 32'h08080808;
      bus.mem_rdata <= 32'h0;
    end else begin
      if (bus.mem_rstrb) bus.mem_rdata <= mem[bus.mem_addr];
      for (int i = 0; i < 4; i++) begin
        if (bus.mem_wmask[i]) mem[bus.mem_addr][8*i +: 8] = bus.mem_wdata[8*i +: 8];
      end
    end
  end

  // Port monitor sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.mem_rstrb === 1'b1) begin
      rstrbCycles++;
      lastRaddr = bus.mem_addr;
    end
    if (bus.mem_wmask !== 4'b0000) begin
      wmaskCycles++;
      lastWaddr = bus.mem_addr;
      lastMask  = bus.mem_wmask;
      lastWdata = bus.mem_wdata;
    end
    if (bus.resp_valid === 1'b1) respCycles++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic isStore, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic keepValid);
    int waited = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("ready before accept", {31'b0, bus.req_ready}, 32'd1);
    bus.req_valid    = 1'b1;
    bus.req_is_store = isStore;
    bus.req_funct3   = f3;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
    @(posedge clk);
    #1;
    if (!keepValid) bus.req_valid = 1'b0;
  endtask

  task automatic waitResp(output int lat);
    lat = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (bus.resp_valid === 1'b1) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic runTxn(input string name, input logic isStore, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata, input int expLat,
                        input logic [31:0] expRdata, input logic expErr);
    int lat;
    applyStimulus(isStore, f3, addr, wdata, 1'b0);
    waitResp(lat);
    checkOutput({name, " latency"}, lat, expLat);
    checkOutput({name, " rdata"}, bus.resp_rdata, expRdata);
    checkOutput({name, " error"}, {31'b0, bus.resp_error}, {31'b0, expErr});
    @(negedge clk);
    checkOutput({name, " pulse width"}, {31'b0, bus.resp_valid}, 32'd0);
  endtask

  initial begin
    int r0;
    int w0;
    int p0;
    reset            = 1'b1;
    bus.req_valid    = 1'b0;
    bus.req_is_store = 1'b0;
    bus.req_funct3   = 3'b000;
    bus.req_addr     = 32'h0;
    bus.req_wdata    = 32'h0;

    repeat (3) @(negedge clk);
    checkOutput("reset req_ready", {31'b0, bus.req_ready}, 32'd0);
    checkOutput("reset resp_valid", {31'b0, bus.resp_valid}, 32'd0);
    checkOutput("reset resp_rdata", bus.resp_rdata, 32'h0);
    checkOutput("reset mem_wmask", {28'b0, bus.mem_wmask}, 32'h0);
    checkOutput("reset mem_rstrb", {31'b0, bus.mem_rstrb}, 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("ready after reset", {31'b0, bus.req_ready}, 32'd1);

    // Aligned word load.
    r0 = rstrbCycles; w0 = wmaskCycles;
    runTxn("lw", 1'b0, 3'b010, 32'h14, 32'h0, 3, 32'hDEADBEEF, 1'b0);
    checkOutput("lw rstrb cycles", rstrbCycles - r0, 32'd1);
    checkOutput("lw mem_addr", {24'b0, lastRaddr}, 32'd5);
    checkOutput("lw no write", wmaskCycles - w0, 32'd0);

    // Sign versus zero extension.
    runTxn("lb", 1'b0, 3'b000, 32'h2, 32'h0, 3, 32'hFFFFFFFF, 1'b0);
    runTxn("lbu", 1'b0, 3'b100, 32'h3, 32'h0, 3, 32'h00000080, 1'b0);
    runTxn("lh", 1'b0, 3'b001, 32'h2, 32'h0, 3, 32'hFFFF80FF, 1'b0);
    runTxn("lhu wrap", 1'b0, 3'b101, 32'h416, 32'h0, 3, 32'h0000DEAD, 1'b0);
    checkOutput("lhu wrap mem_addr", {24'b0, lastRaddr}, 32'd5);

    // Byte store into lane 3 of word 1.
    r0 = rstrbCycles; w0 = wmaskCycles;
    runTxn("sb", 1'b1, 3'b000, 32'h7, 32'h123456AB, 2, 32'h0, 1'b0);
    checkOutput("sb wmask cycles", wmaskCycles - w0, 32'd1);
    checkOutput("sb mask", {28'b0, lastMask}, 32'h8);
    checkOutput("sb mem_addr", {24'b0, lastWaddr}, 32'd1);
    checkOutput("sb wdata", lastWdata, 32'hABABABAB);
    checkOutput("sb memory", mem[1], 32'hAB223344);
    checkOutput("sb no read", rstrbCycles - r0, 32'd0);

    // Error responses never touch memory.
    r0 = rstrbCycles; w0 = wmaskCycles;
    runTxn("lh misaligned", 1'b0, 3'b001, 32'h3, 32'h0, 1, 32'h0, 1'b1);
    runTxn("store f3=100", 1'b1, 3'b100, 32'h8, 32'hFFFFFFFF, 1, 32'h0, 1'b1);
    runTxn("load f3=011", 1'b0, 3'b011, 32'h0, 32'h0, 1, 32'h0, 1'b1);
    runTxn("sw misaligned", 1'b1, 3'b010, 32'h22, 32'h77777777, 1, 32'h0, 1'b1);
    checkOutput("error no read", rstrbCycles - r0, 32'd0);
    checkOutput("error no write", wmaskCycles - w0, 32'd0);

    // Reset raised during the ISSUE cycle of a word store.
    w0 = wmaskCycles; p0 = respCycles;
    applyStimulus(1'b1, 3'b010, 32'h20, 32'h5A5A5A5A, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("rst issue wmask", {28'b0, bus.mem_wmask}, 32'h0);
    checkOutput("rst issue ready", {31'b0, bus.req_ready}, 32'd0);
    @(negedge clk);
    checkOutput("rst held ready", {31'b0, bus.req_ready}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("rst release ready", {31'b0, bus.req_ready}, 32'd1);
    checkOutput("rst no write", wmaskCycles - w0, 32'd0);
    checkOutput("rst no resp", respCycles - p0, 32'd0);
    checkOutput("rst memory", mem[8], 32'h08080808);

    // Back-to-back LW then SW with req_valid held high.
    p0 = respCycles;
    applyStimulus(1'b0, 3'b010, 32'h14, 32'h0, 1'b1);
    bus.req_is_store = 1'b1;
    bus.req_funct3   = 3'b010;
    bus.req_addr     = 32'h20;
    bus.req_wdata    = 32'hCAFEF00D;
    @(negedge clk);
    checkOutput("b2b ready issue", {31'b0, bus.req_ready}, 32'd0);
    @(negedge clk);
    checkOutput("b2b ready wait", {31'b0, bus.req_ready}, 32'd0);
    @(negedge clk);
    checkOutput("b2b ready resp", {31'b0, bus.req_ready}, 32'd0);
    checkOutput("b2b lw valid", {31'b0, bus.resp_valid}, 32'd1);
    checkOutput("b2b lw rdata", bus.resp_rdata, 32'hDEADBEEF);
    checkOutput("b2b lw error", {31'b0, bus.resp_error}, 32'd0);
    @(negedge clk);
    checkOutput("b2b ready idle", {31'b0, bus.req_ready}, 32'd1);
    checkOutput("b2b gap valid", {31'b0, bus.resp_valid}, 32'd0);
    @(posedge clk);
    #1 bus.req_valid = 1'b0;
    @(negedge clk);
    checkOutput("b2b sw ready issue", {31'b0, bus.req_ready}, 32'd0);
    checkOutput("b2b sw mask", {28'b0, bus.mem_wmask}, 32'hF);
    @(negedge clk);
    checkOutput("b2b sw valid", {31'b0, bus.resp_valid}, 32'd1);
    checkOutput("b2b sw rdata", bus.resp_rdata, 32'h0);
    checkOutput("b2b sw error", {31'b0, bus.resp_error}, 32'd0);
    @(negedge clk);
    checkOutput("b2b resp count", respCycles - p0, 32'd2);
    checkOutput("b2b memory", mem[8], 32'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rv_load_store_unit.md
Name: rv_load_store_unit

Overview:
Memory-access stage that sits directly downstream of the core's EXECUTE state and services LOAD/STORE instructions.
- Input: effective address (rs1+Iimm or rs1+Simm), funct3 and rs2 store data.
- Output toward memory: byte-lane-masked accesses on a word-addressed synchronous RAM port.
- Output toward the core: extended load data for register write-back, plus an error flag for misaligned or illegal accesses.

Parameters:
ADDR_W, 8, width of the word index into memory (256 words); byte address bits [ADDR_W+1:2] are used, upper bits ignored.

Ports:
clk  in  1  system clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
req_valid  in  1  core presents a load/store request
req_ready  out  1  unit can accept a request; high only in IDLE
req_is_store  in  1  1 = STORE, 0 = LOAD
req_funct3  in  3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
req_addr  in  32  byte address
req_wdata  in  32  store data (rs2)
resp_valid  out  1  one-cycle pulse: request complete
resp_rdata  out  32  load result, extended; 0 for stores and errors
resp_error  out  1  valid with resp_valid: misaligned or illegal funct3
mem_addr  out  ADDR_W  word index = latched addr[ADDR_W+1:2]
mem_rstrb  out  1  read strobe; mem_rdata valid the following cycle
mem_rdata  in  32  memory read data
mem_wdata  out  32  lane-replicated store data
mem_wmask  out  4  byte write enables; nonzero for exactly one cycle per store

Behaviour:
- FSM states: IDLE, ISSUE, WAIT, RESP.
- Accept: req_valid & req_ready in IDLE. Latch is_store, funct3, addr, wdata.
- Error check at accept:
  - funct3 in {011, 110, 111} is an error.
  - Store with funct3[2]=1 is an error.
  - H/HU with addr[0]=1 is an error.
  - W with addr[1:0]!=0 is an error.
- On error: IDLE->RESP directly. No memory strobe. resp_error=1, resp_rdata=0.
- Otherwise IDLE->ISSUE:
  - Load: mem_rstrb=1; next state WAIT.
  - Store: mem_wmask driven; next state RESP.
- WAIT: register the extracted mem_rdata into the result; next state RESP.
- RESP: resp_valid=1 for exactly one cycle; next state IDLE. A new request may be accepted the cycle after RESP.
- Latency, accept edge to resp_valid high: load 3 cycles, store 2, error 1.
- Load extraction uses latched addr[1:0]:
  - B: byte lane addr[1:0], sign-extended; BU: same lane, zero-extended.
  - H: lane addr[1]*16, sign-extended; HU: same lane, zero-extended.
  - W: full word.
- Store data and masks:
  - SB: mem_wdata={4{wdata[7:0]}}, mask=4'b0001<<addr[1:0].
  - SH: mem_wdata={2{wdata[15:0]}}, mask=4'b0011<<addr[1:0].
  - SW: mem_wdata=wdata, mask=4'b1111.
- Outside ISSUE: mem_wmask=0 and mem_rstrb=0. mem_addr and mem_wdata hold their latched values.
- Address bits above ADDR_W+1 are ignored (wrap-around within memory); no error is raised.
- Reset:
  - State->IDLE; resp_valid=0, resp_error=0, resp_rdata=0, latched request=0.
  - mem_rstrb and mem_wmask are gated by !reset combinationally, so reset asserted during ISSUE suppresses the write in that same cycle.
  - req_ready=0 while reset is high, and 1 the first cycle after reset deasserts.
- req_valid is ignored in every state except IDLE; there is no queuing.

Test Plan:
- LW aligned: mem word 5 = 0xDEADBEEF, req addr=0x14, funct3=010 -> mem_rstrb one cycle with mem_addr=5; resp_valid 3 cycles after accept; resp_rdata=0xDEADBEEF, resp_error=0.
- LB vs LBU: mem word 0 = 0x80FF7F01:
  - LB addr=0x2 -> resp_rdata=0xFFFFFFFF.
  - LBU addr=0x3 -> 0x00000080.
  - LH addr=0x2 -> 0xFFFF80FF.
- SB lane: req_is_store=1, funct3=000, addr=0x7, wdata=0x123456AB -> one cycle with mem_addr=1, mem_wmask=4'b1000, mem_wdata=0xABABABAB; resp_valid 2 cycles after accept, resp_rdata=0.
- Errors:
  - LH addr=0x3 -> resp_valid 1 cycle after accept, resp_error=1, mem_rstrb/mem_wmask never asserted.
  - Store with funct3=100 -> same response.
- Reset mid-store: SW accepted, reset high during the ISSUE cycle -> mem_wmask stays 0000 throughout; resp_valid never pulses; req_ready=1 the cycle after reset drops.
- Back-to-back: req_valid held high with LW then SW -> second accept the cycle after the first resp_valid; req_ready=0 from the accept edge through RESP; both responses correct.
